// File: rtl/id_hazard_stall_unit_if.sv
// Hazard interface between the ID/EX pipeline and the stall/flush controller.
// The master is the pipeline side, which reports the hazard status; the slave is the stall unit.
interface id_hazard_stall_unit_if;
    logic        mem_read_en_ex;
    logic [4:0]  reg_write_addr_ex;
    logic [4:0]  addr_1_id;
    logic [4:0]  addr_2_id;
    logic        uses_rs1_id;
    logic        uses_rs2_id;
    logic        muldiv_ex;
    logic        muldiv_is_div_ex;
    logic        branch_taken_ex;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_bubble;
    logic        ex_mem_bubble;
    logic        muldiv_ready;
    logic [31:0] stall_cycles;

    modport master (
        output mem_read_en_ex, reg_write_addr_ex, addr_1_id, addr_2_id,
               uses_rs1_id, uses_rs2_id, muldiv_ex, muldiv_is_div_ex, branch_taken_ex,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_bubble, muldiv_ready, stall_cycles
    );

    modport slave (
        input  mem_read_en_ex, reg_write_addr_ex, addr_1_id, addr_2_id,
               uses_rs1_id, uses_rs2_id, muldiv_ex, muldiv_is_div_ex, branch_taken_ex,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_bubble, muldiv_ready, stall_cycles
    );
endinterface

// File: rtl/id_hazard_stall_unit.sv
// Stall/flush controller for load-use, multi-cycle MUL/DIV and taken-branch hazards.
// Optional stall-cycle performance counter enabled by macro HAZARD_PERF_CNT_EN.
//
// state   | meaning
// RUN     | normal flow; a MUL/DIV arriving in EX starts its occupancy here
// MD_WAIT | MUL/DIV held in EX, counting down remaining stall cycles
module id_hazard_stall_unit #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input logic                    clk,
    input logic                    rst,
    id_hazard_stall_unit_if.slave  hz
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam logic [CNT_W-1:0] MUL_LEN = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(DIV_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] occ;
    logic             occ_short;
    logic             lu;
    logic             md_stall;
    logic             md_ready;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble;

    assign occ       = hz.muldiv_is_div_ex ? DIV_LEN : MUL_LEN;
    assign occ_short = hz.muldiv_is_div_ex ? (DIV_CYCLES <= 1) : (MUL_CYCLES <= 1);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign lu = hz.mem_read_en_ex && (hz.reg_write_addr_ex != 5'd0) &&
                ((hz.uses_rs1_id && (hz.addr_1_id == hz.reg_write_addr_ex)) ||
                 (hz.uses_rs2_id && (hz.addr_2_id == hz.reg_write_addr_ex)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_stall  = 1'b0;
        md_ready  = 1'b0;
        case (state)
            RUN: begin
                if (hz.muldiv_ex) begin
                    if (occ_short) begin
                        md_ready = 1'b1;
                    end else begin
                        md_stall  = 1'b1;
                        cnt_nxt   = occ - CNT_W'(2);
                        state_nxt = MD_WAIT;
                    end
                end
            end
            MD_WAIT: begin
                if (cnt != '0) begin
                    md_stall = 1'b1;
                    cnt_nxt  = cnt - CNT_W'(1);
                end else begin
                    md_ready  = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if (md_stall) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (hz.branch_taken_ex) begin
            // the redirect squashes the dependent instruction, so a load-use stall is moot
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign hz.pc_stall      = pc_stall;
    assign hz.if_id_stall   = if_id_stall;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_stall   = id_ex_stall;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.ex_mem_bubble = ex_mem_bubble;
    assign hz.muldiv_ready  = md_ready;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pc_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cnt;
`else
    assign hz.stall_cycles = '0;
`endif

endmodule

// File: doc/id_hazard_stall_unit.md
Name: id_hazard_stall_unit

Overview:
- Stall/flush controller sitting alongside the EX-stage operand forwarding logic.
- Handles the hazards that forwarding cannot resolve:
  - load-use dependencies, which need a one-bubble stall;
  - multi-cycle M-extension MUL/DIV occupying EX, which needs a front-end freeze;
  - taken branches/jumps resolved in EX, which need an IF/ID and ID/EX flush.
- Drives the PC enable, IF/ID enable and flush, ID/EX bubble, and EX/MEM bubble.

Parameters:
- MUL_CYCLES, 2, total EX occupancy in cycles of a MUL-class instruction (≥1).
- DIV_CYCLES, 34, total EX occupancy in cycles of a DIV/REM-class instruction (≥1).
- CNT_W, 6, width of the internal occupancy counter; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MEM_READ_EN_EX  in  1  instruction in EX is a load.
- REG_WRITE_ADDR_EX  in  5  rd of the instruction in EX.
- ADDR_1_ID  in  5  rs1 of the instruction in ID.
- ADDR_2_ID  in  5  rs2 of the instruction in ID.
- USES_RS1_ID  in  1  ID instruction reads rs1.
- USES_RS2_ID  in  1  ID instruction reads rs2.
- MULDIV_EX  in  1  instruction in EX is M-extension; stays high while it is held in EX.
- MULDIV_IS_DIV_EX  in  1  1 = DIV/DIVU/REM/REMU, 0 = MUL*.
- BRANCH_TAKEN_EX  in  1  branch/jump in EX redirects the PC.
- PC_STALL  out  1  hold PC.
- IF_ID_STALL  out  1  hold the IF/ID register.
- IF_ID_FLUSH  out  1  load a NOP into IF/ID.
- ID_EX_STALL  out  1  hold the ID/EX register.
- ID_EX_BUBBLE  out  1  load a NOP into ID/EX.
- EX_MEM_BUBBLE  out  1  load a NOP into EX/MEM.
- MULDIV_READY  out  1  single-cycle pulse: the M-extension result is valid in EX this cycle.
- STALL_CYCLES  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high):
  - state = RUN, CNT = 0.
  - All outputs are combinational from state and inputs; with idle inputs during reset, every output is 0.
- States: RUN, MD_WAIT.
- Load-use detect, LU:
  - LU = MEM_READ_EN_EX && REG_WRITE_ADDR_EX != 0 && ((USES_RS1_ID && ADDR_1_ID == REG_WRITE_ADDR_EX) || (USES_RS2_ID && ADDR_2_ID == REG_WRITE_ADDR_EX)).
  - x0 never causes a stall.
- Occupancy L = MULDIV_IS_DIV_EX ? DIV_CYCLES : MUL_CYCLES.
- RUN with MULDIV_EX = 1:
  - If L ≤ 1: no stall; MULDIV_READY = 1 this cycle; stay in RUN.
  - If L ≥ 2: MD stall this cycle; CNT ← L−2; next state MD_WAIT.
- MD_WAIT:
  - MULDIV_EX is ignored (it refers to the same held instruction).
  - CNT ≠ 0: MD stall; CNT ← CNT−1.
  - CNT == 0: no MD stall; MULDIV_READY = 1; next state RUN.
  - A MUL/DIV therefore produces exactly L−1 stall cycles.
- MD stall outputs: PC_STALL = IF_ID_STALL = ID_EX_STALL = EX_MEM_BUBBLE = 1.
- Output priority, highest first:
  1. MD stall.
  2. BRANCH_TAKEN_EX: IF_ID_FLUSH = 1 and ID_EX_BUBBLE = 1; PC_STALL = 0; LU is ignored.
  3. LU: PC_STALL = IF_ID_STALL = ID_EX_BUBBLE = 1, for one cycle. The next cycle has the load in MEM, LU deasserts, and forwarding covers the dependency.
  4. Otherwise: all outputs 0.
- The LU and branch rules also apply in the non-stall MD_WAIT cycle (CNT == 0).
- RESET asserted mid-MD_WAIT: immediate return to RUN and all stalls drop; the pipeline flush is owned by the pipeline registers' own reset.
- ID_EX_STALL and ID_EX_BUBBLE are never both 1.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: STALL_CYCLES is a 32-bit register.
  - Reset to 0.
  - Increments by 1 on every rising edge where PC_STALL = 1.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: STALL_CYCLES is tied to 0 and no counter logic is present.

Test Plan:
- Load x5 in EX, ID reads rs2 = x5 with USES_RS2_ID = 1 → one cycle with PC_STALL = IF_ID_STALL = ID_EX_BUBBLE = 1; with the load moved to MEM the next cycle, all outputs are 0.
- Load with rd = x0 while ID reads x0 → no stall. Repeat with rs1 = x5 and USES_RS1_ID = 0 → no stall.
- DIV in EX, DIV_CYCLES = 34 → PC_STALL, IF_ID_STALL, ID_EX_STALL and EX_MEM_BUBBLE held high for exactly 33 cycles; MULDIV_READY pulses on the 34th cycle; then back to RUN. MUL with MUL_CYCLES = 2 → 1 stall cycle, then a READY pulse.
- BRANCH_TAKEN_EX = 1 concurrent with an LU condition → IF_ID_FLUSH = ID_EX_BUBBLE = 1, PC_STALL = 0, IF_ID_STALL = 0.
- RESET asserted asynchronously at cycle 10 of a DIV stall → all outputs drop to 0 before the next clock edge. After release, a fresh DIV stalls the full 33 cycles again.
- With HAZARD_PERF_CNT_EN defined: LU stall (1) + MUL stall (1) + DIV stall (33) → STALL_CYCLES = 35. Without the macro, STALL_CYCLES stays 0.
